// File: rtl/alu_module.sv
// Registered 8-bit ALU: decodes the opcode, computes the result and status
// flags combinationally, and captures them on the next rising clock edge.

package alu_pkg;

  // Opcode encoding shared with the control unit.
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_LS   = 4'd5,
    OP_RS   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_PASS = 4'd9
  } alu_op_e;

endpackage

module alu_module
  import alu_pkg::*;
#(
  parameter int opsize   = 4,
  parameter int aluwidth = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [opsize-1:0]   opcode,
  input  logic [aluwidth-1:0] in1,
  input  logic [aluwidth-1:0] in2,
  output logic [aluwidth-1:0] out,
  output logic                carry,
  output logic                zero,
  output logic                negative,
  output logic                overflow
);

  localparam int msb = aluwidth - 1;

  typedef struct packed {
    logic [aluwidth-1:0] value;
    logic                carry;
    logic                overflow;
  } alu_res_t;

  alu_res_t          res;
  logic              load;
  logic [aluwidth:0] sum;
  logic [aluwidth:0] diff;
  logic [aluwidth:0] lsh;
  logic [aluwidth:0] rsh;

  // One extra bit catches the carry/borrow; wide shift amounts drain to zero.
  assign sum  = {1'b0, in1} + {1'b0, in2};
  assign diff = {1'b0, in1} - {1'b0, in2};
  assign lsh  = {1'b0, in1} << in2;
  assign rsh  = {in1, 1'b0} >> in2;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    res  = '0;
    load = 1'b1;
    case (opcode)
      opsize'(OP_ADD): begin
        res.value    = sum[msb:0];
        res.carry    = sum[aluwidth];
        res.overflow = (in1[msb] == in2[msb]) && (sum[msb] != in1[msb]);
      end
      opsize'(OP_SUB): begin
        res.value    = diff[msb:0];
        res.carry    = diff[aluwidth];
        res.overflow = (in1[msb] != in2[msb]) && (diff[msb] != in1[msb]);
      end
      opsize'(OP_AND):  res.value = in1 & in2;
      opsize'(OP_OR):   res.value = in1 | in2;
      opsize'(OP_XOR):  res.value = in1 ^ in2;
      opsize'(OP_NOT):  res.value = ~in1;
      opsize'(OP_PASS): res.value = in1;
      opsize'(OP_LS): begin
        res.value = lsh[msb:0];
        res.carry = lsh[aluwidth];
      end
      opsize'(OP_RS): begin
        res.value = rsh[aluwidth:1];
        res.carry = rsh[0];
      end
      default: load = 1'b0;  // NOP and reserved codes hold state
    endcase
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out      <= '0;
      carry    <= 1'b0;
      zero     <= 1'b1;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      out      <= res.value;
      carry    <= res.carry;
      zero     <= (res.value == '0);
      negative <= res.value[msb];
      overflow <= res.overflow;
    end
  end

endmodule

// File: tb/tb_alu_module.sv
// Directed self-checking bench for alu_module: hand-computed result and flag
// vectors, one check per issued operation, sampled 1 ns after the capture edge.

module tb_alu_module;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic [3:0] opcode;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [7:0] out;
  logic       carry;
  logic       zero;
  logic       negative;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  alu_module #(.opsize(4), .aluwidth(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .in1      (in1),
    .in2      (in2),
    .out      (out),
    .carry    (carry),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // Observed vector layout: {out, carry, zero, negative, overflow}.
  function automatic logic [11:0] flags(input logic [7:0] o, input logic c,
                                        input logic z, input logic n, input logic v);
    return {o, c, z, n, v};
  endfunction

  task automatic check(input string tag, input logic [11:0] expected);
    logic [11:0] observed;
    observed = {out, carry, zero, negative, overflow};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed out=%h c=%b z=%b n=%b v=%b, expected out=%h c=%b z=%b n=%b v=%b",
             tag, observed[11:4], observed[3], observed[2], observed[1], observed[0],
             expected[11:4], expected[3], expected[2], expected[1], expected[0]);
    end
  endtask

  task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    opcode = op;
    in1    = a;
    in2    = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk_en = 1'b0;
    reset  = 1'b1;
    opcode = 4'd0;
    in1    = 8'h00;
    in2    = 8'h00;

    // Reset values apply with no clock edges at all.
    #3;
    check("reset_no_clock", flags(8'h00, 0, 1, 0, 0));

    clk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step(4'd0, 8'h12, 8'h34);
    check("nop_after_reset", flags(8'h00, 0, 1, 0, 0));

    // Basic ops, new opcode every cycle.
    step(4'd1, 8'd5, 8'd2); check("add_5_2", flags(8'd7,  0, 0, 0, 0));
    step(4'd2, 8'd5, 8'd2); check("sub_5_2", flags(8'd3,  0, 0, 0, 0));
    step(4'd3, 8'd5, 8'd2); check("and_5_2", flags(8'd0,  0, 1, 0, 0));
    step(4'd4, 8'd5, 8'd2); check("or_5_2",  flags(8'd7,  0, 0, 0, 0));
    step(4'd5, 8'd5, 8'd2); check("ls_5_2",  flags(8'd20, 0, 0, 0, 0));
    step(4'd6, 8'd5, 8'd2); check("rs_5_2",  flags(8'd1,  0, 0, 0, 0));

    // Arithmetic edges.
    step(4'd1, 8'hFF, 8'h01); check("add_wrap",     flags(8'h00, 1, 1, 0, 0));
    step(4'd1, 8'h7F, 8'h01); check("add_overflow", flags(8'h80, 0, 0, 1, 1));
    step(4'd2, 8'h80, 8'h01); check("sub_overflow", flags(8'h7F, 0, 0, 0, 1));
    step(4'd2, 8'h02, 8'h05); check("sub_borrow",   flags(8'hFD, 1, 0, 1, 0));

    // NOP and reserved codes hold the previous result and flags.
    step(4'd0, 8'h11, 8'h22); check("nop_hold",      flags(8'hFD, 1, 0, 1, 0));
    step(4'hF, 8'h00, 8'h00); check("reserved_f",    flags(8'hFD, 1, 0, 1, 0));
    step(4'hA, 8'h00, 8'h00); check("reserved_a",    flags(8'hFD, 1, 0, 1, 0));

    // Shift edges.
    step(4'd5, 8'h81, 8'd1); check("ls_81_1",  flags(8'h02, 1, 0, 0, 0));
    step(4'd6, 8'h81, 8'd1); check("rs_81_1",  flags(8'h40, 1, 0, 0, 0));
    step(4'd5, 8'hFF, 8'd8); check("ls_ff_8",  flags(8'h00, 1, 1, 0, 0));
    step(4'd6, 8'hFF, 8'd9); check("rs_ff_9",  flags(8'h00, 0, 1, 0, 0));
    step(4'd5, 8'h5A, 8'd0); check("ls_5a_0",  flags(8'h5A, 0, 0, 0, 0));
    step(4'd6, 8'hA5, 8'd0); check("rs_a5_0",  flags(8'hA5, 0, 0, 1, 0));

    // Misc logic ops.
    step(4'd8, 8'h0F, 8'hFF); check("not_0f",    flags(8'hF0, 0, 0, 1, 0));
    step(4'd7, 8'hAA, 8'hFF); check("xor_aa_ff", flags(8'h55, 0, 0, 0, 0));
    step(4'd9, 8'h33, 8'hCC); check("pass_33",   flags(8'h33, 0, 0, 0, 0));
    step(4'hF, 8'h99, 8'h01); check("reserved_hold_pass", flags(8'h33, 0, 0, 0, 0));

    // Reset mid-stream discards the pending ADD and clears outputs at once.
    step(4'd1, 8'h80, 8'h90);
    check("add_before_reset", flags(8'h10, 1, 0, 0, 1));
    opcode = 4'd1;
    in1    = 8'd9;
    in2    = 8'd9;
    #2;
    reset = 1'b1;
    #1;
    check("reset_immediate", flags(8'h00, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    check("reset_held_edge", flags(8'h00, 0, 1, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    step(4'd1, 8'd5, 8'd2); check("add_after_reset", flags(8'd7, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, expected completion before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
